uart_digest_tx: RTL and testbench
=================================

UART_DIGEST_TX -- requirements
Module: uart_digest_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 80000000, meaning the CLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the UART bit rate.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port KEY, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port DIGEST, input, 256 bits: the SHA-256 digest to send.
REQ-006 SHALL have port DIGEST_VALID, input, 1 bit: DIGEST is presented.
REQ-007 SHALL have port DIGEST_READY, output, 1 bit: the block accepts a digest.
REQ-008 SHALL have port UART_TXD, output, 1 bit: serial line, 8N1, idle high.
REQ-009 SHALL have port BUSY, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse at the end of the frame.

Function
REQ-011 Bit period SHALL be DIV = CLK_FREQ/BAUD cycles (integer division), i.e. 694 with the defaults.
- Counter rolls over at DIV-1.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE behaviour SHALL be:
- DIGEST_READY=1, BUSY=0, UART_TXD=1.
- Handshake DIGEST_VALID&DIGEST_READY latches DIGEST into an internal register.
- Next cycle: enter START.
REQ-014 Handshake rule SHALL be: DIGEST_READY=0 in all states except IDLE; DIGEST is ignored while not ready.
REQ-015 START SHALL drive UART_TXD=0 for exactly DIV cycles, then go to DATA.
REQ-016 DATA SHALL send 8 bits, LSB first, each held DIV cycles; after bit 7, go to STOP.
REQ-017 STOP SHALL drive UART_TXD=1 for DIV cycles, then:
- If characters remain: go to START directly, with no extra idle gap.
- Else: go to IDLE.
REQ-018 Byte order SHALL be most significant first: byte 0 = DIGEST[255:248], byte 31 = DIGEST[7:0].
REQ-019 DONE SHALL pulse for exactly 1 cycle, on the last cycle of the final stop bit.
- DIGEST_READY SHALL rise on the following cycle.
REQ-020 BUSY SHALL equal the inverse of (state==IDLE).
REQ-021 Character index SHALL never wrap past the last character.
- A new DIGEST_VALID held high during a frame is accepted only after return to IDLE.

Reset
REQ-022 Reset SHALL act asynchronously when KEY=0:
- State=IDLE, all counters=0, digest register=0.
- UART_TXD=1, BUSY=0, DONE=0, DIGEST_READY=1 (only while KEY=1; 0 while KEY=0).
REQ-023 Reset mid-frame SHALL abort the frame immediately.
- UART_TXD returns high with no partial stop bit.
- No DONE pulse.
REQ-024 Release of KEY SHALL take effect on the next rising edge of CLK; no frame starts without a new handshake.

Configuration
REQ-025 Macro HEX_ASCII_EN SHALL select the output encoding when defined:
- Each byte becomes two lowercase ASCII hex characters, upper nibble first ('0'-'9' = 0x30-0x39, 'a'-'f' = 0x61-0x66).
- Followed by 0x0D, 0x0A.
- 66 characters per frame.
REQ-026 Without HEX_ASCII_EN, the block SHALL send the 32 raw bytes only, with no terminator.
- 32 characters per frame.
- The hex-encoding logic SHALL be absent.

Verification
REQ-027 Single frame, raw build (HEX_ASCII_EN off), defaults:
- Stimulus: DIGEST=ba7816bf...f20015ad ("abc"), one-cycle VALID.
- Response: 32 bytes decoded, first 0xBA, last 0xAD.
- DONE at 222080 cycles after the cycle following the handshake.
REQ-028 Single frame, HEX_ASCII_EN build, same digest:
- Response: "ba7816bf...f20015ad\r\n", 66 chars; first byte 0x62, last 0x0A.
- DONE after 458040 cycles.
REQ-029 Bit timing: the start-bit low interval SHALL measure exactly 694 cycles and each data bit 694 cycles.
- Bit pattern of 0xBA on line: 0,0,1,0,1,1,1,0,1,1.
REQ-030 Back-to-back: VALID held high with two different digests:
- Second handshake occurs the cycle after DONE.
- Line stays high exactly one stop bit plus 1 cycle between frames.
- READY=0 throughout each frame.
REQ-031 Reset mid-frame: assert KEY=0 during the DATA bit 3 of byte 5:
- UART_TXD=1 and BUSY=0 asynchronously.
- No DONE.
- After release, line stays idle until a new VALID.
REQ-032 All-zero and all-ones digests (hex build):
- Response: "000...0" and "fff...f" respectively, 64 chars plus CR LF.
- Confirms nibble mapping for 0x0 and 0xF.

Source files
------------

// File: rtl/uart_digest_tx.sv
// uart_digest_tx
//   Sends a 256-bit digest as a UART frame (8N1, idle high), most significant
//   byte first. Default build sends the 32 raw bytes. Defining HEX_ASCII_EN
//   sends each byte as two lowercase hex characters, upper nibble first, then
//   CR LF (66 characters per frame).
//
// Parameters
//   CLK_FREQ      clock frequency in Hz
//   BAUD          UART bit rate; bit period DIV = CLK_FREQ / BAUD cycles
//
// Ports
//   CLK           clock, rising edge
//   KEY           asynchronous active-low reset
//   DIGEST        256-bit digest, sampled on handshake
//   DIGEST_VALID  DIGEST is presented
//   DIGEST_READY  block accepts a digest (IDLE only, and only while KEY=1)
//   UART_TXD      serial output
//   BUSY          a frame is in progress
//   DONE          one-cycle pulse on the last cycle of the final stop bit
//   state_dbg     current FSM state, for observation only
//
// Handshake: a digest is taken on a rising CLK edge where DIGEST_VALID and
// DIGEST_READY are both high; DIGEST is ignored on every other edge, and once
// taken the frame runs to completion (or reset) before READY returns.
module uart_digest_tx #(
    parameter int CLK_FREQ = 80000000,
    parameter int BAUD     = 115200
) (
    input  logic         CLK,
    input  logic         KEY,
    input  logic [255:0] DIGEST,
    input  logic         DIGEST_VALID,
    output logic         DIGEST_READY,
    output logic         UART_TXD,
    output logic         BUSY,
    output logic         DONE,
    output logic [1:0]   state_dbg
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

`ifdef HEX_ASCII_EN
    localparam int N_CHARS = 66;
    localparam int SHIFT   = 4;   // one nibble consumed per character
`else
    localparam int N_CHARS = 32;
    localparam int SHIFT   = 8;   // one byte consumed per character
`endif
    localparam logic [6:0] CHAR_LAST = 7'(N_CHARS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [6:0]       char_idx;
    logic [255:0]     dreg;      // shifted left after each character
    logic [7:0]       cur_char;
    logic             bit_end;
    logic             handshake;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign handshake = DIGEST_VALID && DIGEST_READY;

`ifdef HEX_ASCII_EN
    logic [3:0] nib;
    assign nib = dreg[255:252];

    // Characters 64 and 65 are the CR LF terminator; the nibbles are all
    // consumed by then.
    always_comb begin
        cur_char = 8'h0A;
        if (char_idx == 7'd64) begin
            cur_char = 8'h0D;
        end else if (char_idx == 7'd65) begin
            cur_char = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_char = 8'h30 + {4'd0, nib};
        end else begin
            cur_char = 8'h57 + {4'd0, nib};   // 0x57 + 10 = 'a'
        end
    end
`else
    assign cur_char = dreg[255:248];
`endif

    always_ff @(posedge CLK or negedge KEY) begin
        if (!KEY) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            dreg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        dreg     <= DIGEST;
                        state    <= S_START;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        char_idx <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin   // S_STOP
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (char_idx == CHAR_LAST) begin
                            // Index parks at 0 rather than wrapping into a new frame.
                            char_idx <= '0;
                            state    <= S_IDLE;
                        end else begin
                            char_idx <= char_idx + 1'b1;
                            dreg     <= dreg << SHIFT;
                            state    <= S_START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        UART_TXD = 1'b1;
        case (state)
            S_START: UART_TXD = 1'b0;
            S_DATA:  UART_TXD = cur_char[bit_idx];
            default: UART_TXD = 1'b1;
        endcase
    end

    // Outputs are decoded from state, so an asynchronous reset forces the
    // line high and BUSY low immediately, with no partial stop bit.
    assign DIGEST_READY = (state == S_IDLE) && KEY;
    assign BUSY         = (state != S_IDLE);
    assign DONE         = (state == S_STOP) && bit_end && (char_idx == CHAR_LAST);
    assign state_dbg    = state;

endmodule

// File: tb/tb_uart_digest_tx.sv
// tb_uart_digest_tx
//   Bench for uart_digest_tx with a short bit period (DIV = 4). A line-level
//   model turns every accepted digest into the expected per-cycle values of
//   {UART_TXD, BUSY, DIGEST_READY, DONE}; one process compares them on each
//   falling edge. Directed scenarios: single frame, back-to-back frames,
//   reset mid-frame, all-zero and all-ones digests. Builds with or without
//   HEX_ASCII_EN.
module tb_uart_digest_tx;

    localparam int CLK_FREQ = 40;
    localparam int BAUD     = 10;
    localparam int DIV      = 4;
`ifdef HEX_ASCII_EN
    localparam int N_CHARS  = 66;
    localparam int FRAME_CYC = 2640;   // 66 chars * 10 bits * 4
`else
    localparam int N_CHARS  = 32;
    localparam int FRAME_CYC = 1280;   // 32 chars * 10 bits * 4
`endif

    localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMP  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ZERO = '0;
    localparam logic [255:0] D_ONES = '1;

    // clock / reset
    logic         clk;
    logic         key;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         uart_txd;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_digest_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .CLK          (clk),
        .KEY          (key),
        .DIGEST       (digest),
        .DIGEST_VALID (digest_valid),
        .DIGEST_READY (digest_ready),
        .UART_TXD     (uart_txd),
        .BUSY         (busy),
        .DONE         (done),
        .state_dbg    (state_dbg)
    );

    int chk_count  = 0;
    int fail_count = 0;
    int cyc        = 0;
    int hs_count   = 0;
    int hs_cyc     = 0;
    int done_count = 0;
    int done_cyc   = 0;

    // expected {txd, busy, ready, done} per cycle
    logic [3:0] exp_q[$];

    // Character k of the frame for digest d, straight from the encoding rules.
    function automatic logic [7:0] char_at(input logic [255:0] d, input int k);
        logic [255:0] t;
        logic [7:0]   b;
        logic [3:0]   n;
`ifdef HEX_ASCII_EN
        if (k == 64) return 8'h0D;
        if (k == 65) return 8'h0A;
        t = d >> (8 * (31 - k / 2));
        b = t[7:0];
        n = (k % 2 == 0) ? b[7:4] : b[3:0];
        if (n < 4'd10) return 8'("0") + 8'(n);
        return 8'("a") + 8'(n) - 8'd10;
`else
        t = d >> (8 * (31 - k));
        b = t[7:0];
        n = 4'd0;
        return b;
`endif
    endfunction

    task automatic push_frame(input logic [255:0] d);
        logic [7:0] c;
        for (int k = 0; k < N_CHARS; k++) begin
            c = char_at(d, k);
            for (int i = 0; i < DIV; i++) exp_q.push_back(4'b0100);
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < DIV; i++) exp_q.push_back({c[b], 3'b100});
            for (int i = 0; i < DIV - 1; i++) exp_q.push_back(4'b1100);
            exp_q.push_back((k == N_CHARS - 1) ? 4'b1101 : 4'b1100);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // compare process: one comparison per cycle against the line model
    logic [3:0] exp_now;
    logic [3:0] act_now;
    always @(negedge clk) begin
        if (!key) exp_q.delete();
        exp_now = (exp_q.size() > 0) ? exp_q[0] : {1'b1, 1'b0, key, 1'b0};
        act_now = {uart_txd, busy, digest_ready, done};
        chk_count++;
        if (act_now !== exp_now) begin
            fail_count++;
            $display("FAIL line cyc=%0d {txd,busy,ready,done} actual=%b required=%b",
                     cyc, act_now, exp_now);
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (key && digest_valid) begin
            push_frame(digest);
            hs_count++;
            hs_cyc = cyc;
        end
        cyc++;
    end

    // driver tasks (inputs change 2 time units after a rising edge)
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 10000) begin
            step(1);
            n++;
        end
        check("hs_timeout", hs_count, target);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 10000) begin
            step(1);
            n++;
        end
        check("done_timeout", done_count, target);
    endtask

    task automatic send_one(input logic [255:0] d);
        digest       = d;
        digest_valid = 1'b1;
        wait_hs(hs_count + 1);
        digest_valid = 1'b0;
    endtask

    logic [0:9] pat;
    int         cnt_before;

    initial begin
        key          = 1'b0;
        digest       = '0;
        digest_valid = 1'b0;

        // model pins
`ifdef HEX_ASCII_EN
        check("pin_first_abc", char_at(D_ABC, 0), 8'h62);
        check("pin_second_abc", char_at(D_ABC, 1), 8'h61);
        check("pin_cr", char_at(D_ABC, 64), 8'h0D);
        check("pin_last_abc", char_at(D_ABC, 65), 8'h0A);
        check("pin_zero", char_at(D_ZERO, 7), 8'h30);
        check("pin_ones", char_at(D_ONES, 8), 8'h66);
`else
        check("pin_first_abc", char_at(D_ABC, 0), 8'hBA);
        check("pin_second_abc", char_at(D_ABC, 1), 8'h78);
        check("pin_last_abc", char_at(D_ABC, 31), 8'hAD);
        check("pin_zero", char_at(D_ZERO, 7), 8'h00);
        check("pin_ones", char_at(D_ONES, 8), 8'hFF);
`endif

        // reset state while KEY=0
        step(3);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", digest_ready, 0);
        key = 1'b1;
        step(3);
        check("idle_ready", digest_ready, 1);

        // single frame: first-character bit pattern and DONE latency
        send_one(D_ABC);
        for (int j = 0; j < 10; j++) begin
            step((j == 0) ? DIV / 2 : DIV);
            pat[j] = uart_txd;
        end
`ifdef HEX_ASCII_EN
        check("first_char_bits", pat, 10'b0010001101);
`else
        check("first_char_bits", pat, 10'b0010111011);
`endif
        wait_done(1);
        check("done_latency", done_cyc - hs_cyc, FRAME_CYC);
        step(5);

        // back-to-back with VALID held high
        digest       = D_ABC;
        digest_valid = 1'b1;
        wait_hs(2);
        digest = D_EMP;
        wait_hs(3);
        digest_valid = 1'b0;
        check("b2b_done_count", done_count, 2);
        check("b2b_hs_after_done", hs_cyc - done_cyc, 1);
        wait_done(3);
        step(5);

        // reset during data bit 3 of byte 5
        send_one(D_EMP);
        step(5 * 10 * DIV + 4 * DIV + 1);
        cnt_before = done_count;
        #1 key = 1'b0;
        #1;
        check("abort_txd", uart_txd, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", digest_ready, 0);
        step(3);
        key = 1'b1;
        step(60);
        check("abort_no_done", done_count, cnt_before);
        check("abort_no_hs", hs_count, 4);

        // all-zero and all-ones digests
        send_one(D_ZERO);
        wait_done(cnt_before + 1);
        step(3);
        send_one(D_ONES);
        wait_done(cnt_before + 2);
        check("ones_latency", done_cyc - hs_cyc, FRAME_CYC);
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
        $finish;
    end

endmodule
